// File: rtl/io_bus_master_if.sv
// Core-side request/response handshake and IO-side bus of the IO bus master.
interface io_bus_master_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [7:0]  io_addr;
    logic        io_en;
    logic        io_we;
    logic [31:0] io_data_write;
    logic [31:0] io_data_read;

    modport master (
        input  req_valid, req_we, req_addr, req_wdata, io_data_read,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
               io_addr, io_en, io_we, io_data_write
    );

    modport slave (
        output req_valid, req_we, req_addr, req_wdata, io_data_read,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
               io_addr, io_en, io_we, io_data_write
    );
endinterface

// File: rtl/io_bus_master.sv
// IO bus master: turns single core requests into IO bus write/read strobes
// inside a 256-byte window, answering each accepted request with one
// response pulse. Out-of-window requests get an error response without
// touching the IO bus.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | ready for a request
// S_WRITE | single io_en/io_we cycle, response presented in same cycle
// S_READ  | io_en held READ_LAT cycles, counter counts down to 0
// S_RESP  | read response presented with captured io_data_read
// S_ERR   | error response presented, IO bus untouched
module io_bus_master #(
    parameter logic [31:0] IO_BASE  = 32'h8000_0000,
    parameter int unsigned READ_LAT = 1
) (
    input  logic            clk,
    input  logic            resetb,
    io_bus_master_if.master bus,
    output logic            busy
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_READ  = 3'd2,
        S_RESP  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    localparam logic [3:0] LAT_M1 = 4'(READ_LAT - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        io_en_q, io_en_d;
    logic        io_we_q, io_we_d;
    logic [7:0]  io_addr_q, io_addr_d;
    logic [31:0] io_data_write_q, io_data_write_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_err_q, rsp_err_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;

    logic accept;
    logic hit;

    // Handshake and status are gated by reset so nothing looks ready or busy while held
    assign bus.req_ready = resetb && (state_q == S_IDLE);
    assign busy          = resetb && (state_q != S_IDLE);
    assign accept        = bus.req_valid && bus.req_ready;
    assign hit           = (bus.req_addr[31:8] == IO_BASE[31:8]);

    assign bus.io_en         = io_en_q;
    assign bus.io_we         = io_we_q;
    assign bus.io_addr       = io_addr_q;
    assign bus.io_data_write = io_data_write_q;
    assign bus.rsp_valid     = rsp_valid_q;
    assign bus.rsp_err       = rsp_err_q;
    assign bus.rsp_rdata     = rsp_rdata_q;

    // Next-state and next-output logic; strobes default low, data outputs hold
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        io_en_d         = 1'b0;
        io_we_d         = 1'b0;
        io_addr_d       = io_addr_q;
        io_data_write_d = io_data_write_q;
        rsp_valid_d     = 1'b0;
        rsp_err_d       = rsp_err_q;
        rsp_rdata_d     = rsp_rdata_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (!hit) begin
                        state_d     = S_ERR;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = 32'h0;
                    end else if (bus.req_we) begin
                        state_d         = S_WRITE;
                        io_en_d         = 1'b1;
                        io_we_d         = 1'b1;
                        io_addr_d       = bus.req_addr[7:0];
                        io_data_write_d = bus.req_wdata;
                        rsp_valid_d     = 1'b1;
                        rsp_err_d       = 1'b0;
                        rsp_rdata_d     = 32'h0;
                    end else begin
                        state_d   = S_READ;
                        io_en_d   = 1'b1;
                        io_addr_d = bus.req_addr[7:0];
                        cnt_d     = LAT_M1;
                    end
                end
            end
            S_READ: begin
                // Last read cycle: capture the read data as the strobe drops
                if (cnt_q == 4'd0) begin
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = bus.io_data_read;
                end else begin
                    cnt_d   = cnt_q - 4'd1;
                    io_en_d = 1'b1;
                end
            end
            S_WRITE, S_RESP, S_ERR: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; synchronous active-low reset aborts any access
    always_ff @(posedge clk) begin
        if (!resetb) begin
            state_q         <= S_IDLE;
            cnt_q           <= 4'd0;
            io_en_q         <= 1'b0;
            io_we_q         <= 1'b0;
            io_addr_q       <= 8'h0;
            io_data_write_q <= 32'h0;
            rsp_valid_q     <= 1'b0;
            rsp_err_q       <= 1'b0;
            rsp_rdata_q     <= 32'h0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            io_en_q         <= io_en_d;
            io_we_q         <= io_we_d;
            io_addr_q       <= io_addr_d;
            io_data_write_q <= io_data_write_d;
            rsp_valid_q     <= rsp_valid_d;
            rsp_err_q       <= rsp_err_d;
            rsp_rdata_q     <= rsp_rdata_d;
        end
    end
endmodule

// File: tb/tb_io_bus_master.sv
// Scoreboard bench for io_bus_master: the driver pushes expected responses
// and IO writes at acceptance, a negedge monitor pops and compares them.
module tb_io_bus_master;
    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam int unsigned RL   = 3;

    logic clk;
    logic resetb;
    logic busy;

    io_bus_master_if bus_if ();

    io_bus_master #(.IO_BASE(BASE), .READ_LAT(RL)) dut (
        .clk    (clk),
        .resetb (resetb),
        .bus    (bus_if),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        longint      t;
        logic        err;
        logic [31:0] rdata;
        bit          rd;
    } rsp_t;

    typedef struct {
        longint      t;
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;

    rsp_t rq[$];
    wr_t  wq[$];

    logic [31:0] ref_mem [256];
    logic [31:0] dev_mem [256];

    int errors = 0;
    int checks = 0;
    int rd_run = 0;

    longint prev_t   = 0;
    int     prev_len = 0;
    bit     have_prev = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // IO device: a register file behind the bus
    always_comb begin
        bus_if.io_data_read = (bus_if.io_en && !bus_if.io_we) ? dev_mem[bus_if.io_addr] : 32'hBAAD_F00D;
    end

    always @(posedge clk) begin
        if (resetb && bus_if.io_en && bus_if.io_we)
            dev_mem[bus_if.io_addr] <= bus_if.io_data_write;
    end

    // Monitor: compares IO writes and responses against the scoreboard queues
    always @(negedge clk) begin
        if (!resetb) begin
            rd_run = 0;
        end else begin
            if (bus_if.io_en && !bus_if.io_we) rd_run++;
            chk("io_we_without_en", 32'(bus_if.io_we & ~bus_if.io_en), 32'h0);
            if (bus_if.io_en && bus_if.io_we) begin
                if (wq.size() == 0) begin
                    chk("unexpected_io_write", 32'(bus_if.io_addr), 32'hFFFF_FFFF);
                end else begin
                    wr_t w;
                    w = wq.pop_front();
                    chk("io_addr", 32'(bus_if.io_addr), 32'(w.addr));
                    chk("io_data_write", bus_if.io_data_write, w.data);
                    chk("io_write_time", 32'($time), 32'(w.t));
                end
            end
            if (bus_if.rsp_valid) begin
                if (rq.size() == 0) begin
                    chk("unexpected_rsp", 32'(bus_if.rsp_valid), 32'h0);
                end else begin
                    rsp_t r;
                    r = rq.pop_front();
                    chk("rsp_err", 32'(bus_if.rsp_err), 32'(r.err));
                    chk("rsp_rdata", bus_if.rsp_rdata, r.rdata);
                    chk("rsp_time", 32'($time), 32'(r.t));
                    if (r.rd) chk("read_strobe_cycles", 32'(rd_run), 32'(RL));
                    rd_run = 0;
                end
            end
        end
    end

    // Drives one request from a negedge, waits for acceptance, pushes expectations
    task automatic issue(input bit we, input logic [31:0] a, input logic [31:0] d, input bit b2b);
        bit     ok;
        bit     rdy;
        longint t_acc;
        rsp_t   r;
        wr_t    w;
        int     len;
        ok = 0;
        bus_if.req_valid = 1'b1;
        bus_if.req_we    = we;
        bus_if.req_addr  = a;
        bus_if.req_wdata = d;
        for (int i = 0; i < 100 && !ok; i++) begin
            rdy = bus_if.req_ready;
            @(posedge clk);
            if (rdy) ok = 1;
            else @(negedge clk);
        end
        if (!ok) begin
            chk("accept_timeout", 32'h0, 32'h1);
            bus_if.req_valid = 1'b0;
            return;
        end
        t_acc = $time;
        if (a[31:8] != BASE[31:8]) begin
            r = '{t: t_acc + 5, err: 1'b1, rdata: 32'h0, rd: 1'b0};
            rq.push_back(r);
            len = 2;
        end else if (we) begin
            w = '{t: t_acc + 5, addr: a[7:0], data: d};
            wq.push_back(w);
            r = '{t: t_acc + 5, err: 1'b0, rdata: 32'h0, rd: 1'b0};
            rq.push_back(r);
            ref_mem[a[7:0]] = d;
            len = 2;
        end else begin
            r = '{t: t_acc + 10 * RL + 5, err: 1'b0, rdata: ref_mem[a[7:0]], rd: 1'b1};
            rq.push_back(r);
            len = RL + 2;
        end
        if (b2b && have_prev) chk("b2b_period", 32'(t_acc - prev_t), 32'(prev_len * 10));
        prev_t    = t_acc;
        prev_len  = len;
        have_prev = 1;
        @(negedge clk);
        bus_if.req_valid = 1'b0;
        bus_if.req_we    = 1'($urandom);
        bus_if.req_addr  = $urandom;
        bus_if.req_wdata = $urandom;
    endtask

    task automatic chk_reset_outputs();
        chk("rst_io_en", 32'(bus_if.io_en), 32'h0);
        chk("rst_io_we", 32'(bus_if.io_we), 32'h0);
        chk("rst_io_addr", 32'(bus_if.io_addr), 32'h0);
        chk("rst_io_data_write", bus_if.io_data_write, 32'h0);
        chk("rst_rsp_valid", 32'(bus_if.rsp_valid), 32'h0);
        chk("rst_rsp_err", 32'(bus_if.rsp_err), 32'h0);
        chk("rst_rsp_rdata", bus_if.rsp_rdata, 32'h0);
        chk("rst_req_ready", 32'(bus_if.req_ready), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        bit          we;
        int          gap;

        for (int i = 0; i < 256; i++) begin
            ref_mem[i] = $urandom;
            dev_mem[i] = ref_mem[i];
        end
        resetb           = 1'b0;
        bus_if.req_valid = 1'b0;
        bus_if.req_we    = 1'b0;
        bus_if.req_addr  = 32'h0;
        bus_if.req_wdata = 32'h0;

        repeat (3) @(negedge clk);
        chk_reset_outputs();
        resetb = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", 32'(bus_if.req_ready), 32'h1);
        chk("busy_after_reset", 32'(busy), 32'h0);

        // Single write, then idle/ready two cycles after acceptance
        issue(1'b1, 32'h8000_0000, 32'h0000_00A5, 1'b0);
        @(negedge clk);
        chk("write_ready_n2", 32'(bus_if.req_ready), 32'h1);
        chk("write_io_en_n2", 32'(bus_if.io_en), 32'h0);

        // Known-data read
        ref_mem[8'h10] = 32'h1234_5678;
        dev_mem[8'h10] = 32'h1234_5678;
        issue(1'b0, 32'h8000_0010, 32'h0, 1'b0);
        repeat (6) @(negedge clk);

        // Out-of-window read
        issue(1'b0, 32'h4000_0000, 32'h0, 1'b0);
        repeat (2) @(negedge clk);

        // Back-to-back alternating writes
        have_prev = 0;
        for (int i = 0; i < 4; i++)
            issue(1'b1, (i % 2 == 0) ? 32'h8000_0000 : 32'h8000_0001, $urandom, 1'b1);
        repeat (3) @(negedge clk);

        // Reset during the second read cycle aborts the access
        issue(1'b0, 32'h8000_0020, 32'h0, 1'b0);
        @(negedge clk);
        resetb = 1'b0;
        rq.delete();
        wq.delete();
        have_prev = 0;
        @(negedge clk);
        chk_reset_outputs();
        @(negedge clk);
        resetb = 1'b1;
        @(negedge clk);
        chk("ready_after_abort", 32'(bus_if.req_ready), 32'h1);
        chk("io_en_after_abort", 32'(bus_if.io_en), 32'h0);

        // Randomized mix of hits, misses, reads, writes, with and without gaps
        for (int n = 0; n < 60; n++) begin
            we  = 1'($urandom);
            gap = $urandom_range(0, 2);
            if ($urandom_range(0, 3) != 0) begin
                a = {BASE[31:8], 8'($urandom)};
            end else begin
                a = $urandom;
                if (a[31:8] == BASE[31:8]) a[31] = ~a[31];
            end
            d = $urandom;
            repeat (gap) @(negedge clk);
            issue(we, a, d, gap == 0);
        end

        for (int i = 0; i < 20 && rq.size() != 0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        chk("rsp_queue_drained", 32'(rq.size()), 32'h0);
        chk("wr_queue_drained", 32'(wq.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/io_bus_master.md
IO_BUS_MASTER -- requirements
Module: io_bus_master

Interface
REQ-001 Parameter IO_BASE, default 32'h8000_0000, base address of the 256-byte IO window; only bits [31:8] are compared.
REQ-002 Parameter READ_LAT, default 1, number of cycles io_en is held for a read; legal range 1..15.
REQ-003 clk  in  1  clock; all logic rising-edge.
REQ-004 resetb  in  1  reset, synchronous, active-low.
REQ-005 req_valid  in  1  core presents an IO request.
REQ-006 req_ready  out  1  master can accept a request this cycle.
REQ-007 req_we  in  1  1 = write, 0 = read.
REQ-008 req_addr  in  32  full byte address of the request.
REQ-009 req_wdata  in  32  write data.
REQ-010 rsp_valid  out  1  one-cycle response pulse; no backpressure.
REQ-011 rsp_rdata  out  32  read data; 0 for writes and errors.
REQ-012 rsp_err  out  1  address outside the IO window; qualified by rsp_valid.
REQ-013 io_addr  out  8  IO bus address (req_addr[7:0]).
REQ-014 io_en  out  1  IO bus access strobe.
REQ-015 io_we  out  1  IO bus write strobe.
REQ-016 io_data_write  out  32  IO bus write data.
REQ-017 io_data_read  in  32  IO bus read data; valid only while io_en=1 and io_we=0.
REQ-018 busy  out  1  high in any state other than IDLE.

Function
REQ-019 FSM states: IDLE, WRITE, READ, RESP, ERR.
REQ-020 req_ready = 1 only in IDLE; a request is accepted on the cycle where req_valid && req_ready.
REQ-021 Window hit = (req_addr[31:8] == IO_BASE[31:8]); the request is registered at acceptance, so later req_* changes have no effect.
REQ-022 Accepted miss -> ERR for 1 cycle: rsp_valid=1, rsp_err=1, rsp_rdata=0; io_en/io_we stay 0 -> IDLE.
REQ-023 Accepted hit write at cycle N -> WRITE at N+1: io_en=1, io_we=1, io_addr=req_addr[7:0], io_data_write=req_wdata, rsp_valid=1, rsp_err=0, rsp_rdata=0, all for exactly one cycle; IDLE at N+2.
REQ-024 Accepted hit read at cycle N -> READ for cycles N+1 .. N+READ_LAT with io_en=1, io_we=0, io_addr stable; 4-bit down-counter loaded with READ_LAT-1.
REQ-025 io_data_read is sampled on the clock edge ending cycle N+READ_LAT -> RESP at N+READ_LAT+1 with rsp_valid=1, rsp_err=0, rsp_rdata=sampled value; IDLE at N+READ_LAT+2.
REQ-026 Throughput: back-to-back writes every 2 cycles; back-to-back reads every READ_LAT+2 cycles; errors every 2 cycles.
REQ-027 Outside WRITE/READ, io_en=0 and io_we=0; io_addr and io_data_write hold their last driven values.
REQ-028 io_we never asserts without io_en; exactly one io_en write cycle per accepted hit write.
REQ-029 rsp_valid asserts exactly once per accepted request and never without one; rsp_rdata and rsp_err are held until the next response.
REQ-030 req_valid while busy is ignored; the request must be held by the core until accepted.

Reset
REQ-031 While resetb=0 at a clock edge: state=IDLE, counter=0, io_en=0, io_we=0, io_addr=0, io_data_write=0, rsp_valid=0, rsp_err=0, rsp_rdata=0.
REQ-032 req_ready=0 and busy=0 while resetb=0; req_ready=1 on the first cycle after resetb returns high.
REQ-033 Reset mid-access aborts the transfer: no further io_en, no response for the aborted request.

Verification
REQ-034 Write 0x0000_00A5 to 0x8000_0000 at cycle N -> cycle N+1: io_en=1, io_we=1, io_addr=0x00, io_data_write=0xA5, rsp_valid=1, rsp_err=0; cycle N+2: req_ready=1, io_en=0.
REQ-035 READ_LAT=3, read 0x8000_0010 with io_data_read=0x1234_5678 -> io_en=1, io_we=0 for 3 cycles; rsp_valid with rsp_rdata=0x1234_5678 on cycle N+4.
REQ-036 Read of 0x4000_0000 -> rsp_valid=1, rsp_err=1, rsp_rdata=0 on N+1; io_en never asserts.
REQ-037 req_valid held high with alternating writes to 0x8000_0000 and 0x8000_0001 -> one accepted request every 2 cycles, io_addr 0x00 then 0x01, 4 responses for 4 requests.
REQ-038 resetb low during the 2nd READ cycle (READ_LAT=3) -> io_en=0 next cycle, no rsp_valid; req_ready=1 on the first cycle after resetb returns high.
REQ-039 req_addr/req_wdata changed while busy -> io_addr and io_data_write keep the values captured at acceptance.
